// File: rtl/filtro_secuenciador_pkg.sv
// Shared types and helpers for the filter-section sequencer:
// FSM state encoding, section index constants and the enable scan.
package filtro_secuenciador_pkg;

    localparam int N_DEF       = 16;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SEC_NONE = 2'd0;
    localparam logic [1:0] SEC_1    = 2'd1;
    localparam logic [1:0] SEC_2    = 2'd2;
    localparam logic [1:0] SEC_3    = 2'd3;

    // Lowest enabled section strictly above cur; SEC_NONE when nothing is left.
    // en[0] enables section 1, en[2] enables section 3.
    function automatic logic [1:0] next_sec(input logic [2:0] en, input logic [1:0] cur);
        logic [1:0] r;
        r = SEC_NONE;
        if ((cur < SEC_1) && en[0]) begin
            r = SEC_1;
        end else if ((cur < SEC_2) && en[1]) begin
            r = SEC_2;
        end else if ((cur < SEC_3) && en[2]) begin
            r = SEC_3;
        end
        return r;
    endfunction

endpackage

// File: rtl/filtro_secuenciador_if.sv
// Request/response bus between the sequencer (master) and the shared
// filter-section core (slave).
interface filtro_secuenciador_if #(
    parameter int N = 16
) ();
    import filtro_secuenciador_pkg::*;

    logic         sec_start;
    logic [1:0]   sec_sel;
    logic [N-1:0] sec_x;
    logic         sec_done;
    logic [N-1:0] sec_y;

    modport master (
        output sec_start,
        output sec_sel,
        output sec_x,
        input  sec_done,
        input  sec_y
    );

    modport slave (
        input  sec_start,
        input  sec_sel,
        input  sec_x,
        output sec_done,
        output sec_y
    );

endinterface

// File: rtl/filtro_secuenciador_acumulador.sv
// N+2-bit signed accumulator of section outputs with the N-bit result view.
// Macro SATURATION_EN: when defined the N-bit view clamps to the signed
// N-bit range; otherwise it is the low N bits (modular sum).
module filtro_secuenciador_acumulador
    import filtro_secuenciador_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         add_en,
    input  logic [N-1:0] din,
    output logic [N-1:0] result_n
);

    logic signed [N+1:0] acc;

    // Accumulate sign-extended section outputs; cleared at the start of each sample.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= acc + $signed({{2{din[N-1]}}, din});
        end
    end

`ifdef SATURATION_EN
    localparam logic signed [N+1:0] SAT_MAX = {3'b000, {(N-1){1'b1}}};
    localparam logic signed [N+1:0] SAT_MIN = {3'b111, {(N-1){1'b0}}};

    // Clamp the wide sum into the signed N-bit range.
    always_comb begin
        result_n = acc[N-1:0];
        if (acc > SAT_MAX) begin
            result_n = SAT_MAX[N-1:0];
        end else if (acc < SAT_MIN) begin
            result_n = SAT_MIN[N-1:0];
        end
    end
`else
    // Two's-complement wrap: keep the low N bits of the sum.
    always_comb begin
        result_n = acc[N-1:0];
    end
`endif

endmodule

// File: rtl/filtro_secuenciador.sv
// Sequences one shared filter-section core over sections 1..3 per sample,
// summing the returned outputs into result. Build macro SATURATION_EN
// (handled in the accumulator) selects clamped instead of wrapped result.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for sample_tick; latches xk and section enables
// ST_ISSUE | one-cycle sec_start for section k
// ST_WAIT  | waiting for sec_done or timeout on section k
// ST_DONE  | publish result, pulse result_valid next cycle
module filtro_secuenciador
    import filtro_secuenciador_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [N-1:0]          xk,
    input  logic                  sw1,
    input  logic                  sw2,
    input  logic                  sw3,
    filtro_secuenciador_if.master sec_bus,
    output logic [N-1:0]          result,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t         state, state_nxt;
    logic [1:0]     k_reg, k_nxt;
    logic [2:0]     sw_reg;
    logic [N-1:0]   x_reg;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   acc_result;

    logic [2:0]     sw_in;
    logic [1:0]     first_k;
    logic [1:0]     after_k;
    logic           load_in, acc_clear, acc_add;
    logic           cnt_load, cnt_dec;
    logic           set_to, set_ovr, res_load;
    logic           start_c;
    logic [1:0]     sel_c;

    assign sw_in   = {sw3, sw2, sw1};
    assign first_k = next_sec(sw_in, SEC_NONE);
    assign after_k = next_sec(sw_reg, k_reg);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_nxt = state;
        k_nxt     = k_reg;
        load_in   = 1'b0;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        set_to    = 1'b0;
        set_ovr   = 1'b0;
        res_load  = 1'b0;
        start_c   = 1'b0;
        sel_c     = SEC_NONE;
        unique case (state)
            ST_IDLE: begin
                if (sample_tick) begin
                    load_in   = 1'b1;
                    acc_clear = 1'b1;
                    k_nxt     = first_k;
                    state_nxt = (first_k != SEC_NONE) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_ISSUE: begin
                start_c   = 1'b1;
                sel_c     = k_reg;
                cnt_load  = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                sel_c = k_reg;
                if (sec_bus.sec_done || (cnt == '0)) begin
                    acc_add   = sec_bus.sec_done;
                    set_to    = ~sec_bus.sec_done;
                    k_nxt     = after_k;
                    state_nxt = (after_k != SEC_NONE) ? ST_ISSUE : ST_DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_DONE: begin
                res_load  = 1'b1;
                k_nxt     = SEC_NONE;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (sample_tick && (state != ST_IDLE)) begin
            set_ovr = 1'b1;
        end
    end

    // Datapath registers: latched sample, section index, timeout down-counter, flags, result.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_reg        <= SEC_NONE;
            sw_reg       <= '0;
            x_reg        <= '0;
            cnt          <= '0;
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            k_reg <= k_nxt;
            if (load_in) begin
                sw_reg <= sw_in;
                x_reg  <= xk;
            end
            if (cnt_load) begin
                cnt <= CW'(TIMEOUT - 1);
            end else if (cnt_dec) begin
                cnt <= cnt - 1'b1;
            end
            if (res_load) begin
                result <= acc_result;
            end
            result_valid <= res_load;
            if (set_ovr) begin
                overrun <= 1'b1;
            end
            if (set_to) begin
                timeout_err <= 1'b1;
            end
        end
    end

    filtro_secuenciador_acumulador #(.N(N)) u_acc (
        .clk      (clk),
        .reset    (reset),
        .clear    (acc_clear),
        .add_en   (acc_add),
        .din      (sec_bus.sec_y),
        .result_n (acc_result)
    );

    assign sec_bus.sec_start = start_c;
    assign sec_bus.sec_sel   = sel_c;
    assign sec_bus.sec_x     = x_reg;
    assign busy              = (state != ST_IDLE);

endmodule

// File: tb/tb_filtro_secuenciador.sv
// Directed bench for filtro_secuenciador with a one-cycle-latency core model.
module tb_filtro_secuenciador;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [15:0] xk = '0;
    logic        sw1 = 1'b0, sw2 = 1'b0, sw3 = 1'b0;
    logic [15:0] result;
    logic        result_valid, busy, overrun, timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    filtro_secuenciador_if #(.N(16)) bus ();

    filtro_secuenciador #(.N(16), .TIMEOUT(255)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .xk           (xk),
        .sw1          (sw1),
        .sw2          (sw2),
        .sw3          (sw3),
        .sec_bus      (bus.master),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: answers one cycle after sec_start, except for a hung section.
    logic [15:0] y_tab [1:3];
    bit          hang_en = 0;
    logic [1:0]  hang_sel = 2'd1;
    bit          resp_pend = 0;
    logic [15:0] resp_y = '0;
    int          issue_cnt = 0;
    logic [1:0]  issue_sel [0:7];
    logic [15:0] issue_x   [0:7];

    initial begin
        bus.sec_done = 1'b0;
        bus.sec_y    = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.sec_done = 1'b0;
            if (resp_pend) begin
                bus.sec_done = 1'b1;
                bus.sec_y    = resp_y;
                resp_pend    = 0;
            end
            if (bus.sec_start === 1'b1) begin
                if (issue_cnt < 8) begin
                    issue_sel[issue_cnt] = bus.sec_sel;
                    issue_x[issue_cnt]   = bus.sec_x;
                end
                issue_cnt++;
                if (!(hang_en && bus.sec_sel == hang_sel) && bus.sec_sel != 2'd0) begin
                    resp_pend = 1;
                    resp_y    = y_tab[bus.sec_sel];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Tick one sample; optionally inject a second tick inj cycles later.
    task automatic run_sample(input string tag, input logic [2:0] sw, input logic [15:0] x,
                              input int inj, output int lat, output logic [15:0] res);
        int t0;
        bit seen;
        issue_cnt = 0;
        {sw3, sw2, sw1} = sw;
        xk = x;
        sample_tick = 1'b1;
        t0 = cyc;
        seen = 0;
        lat = -1;
        res = 'x;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk);
            #1;
            sample_tick = ((cyc - t0) == inj) ? 1'b1 : 1'b0;
            xk = ~x;
            if (result_valid) begin
                seen = 1;
                lat  = cyc - t0;
                res  = result;
            end
        end
        sample_tick = 1'b0;
        chk({tag, "_valid_seen"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    int          lat;
    logic [15:0] res;

    initial begin
        y_tab[1] = 16'd0;
        y_tab[2] = 16'd0;
        y_tab[3] = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        chk("rst_start", 32'(bus.sec_start), 32'd0);
        chk("rst_sel", 32'(bus.sec_sel), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: all sections, 100 + 200 - 50
        y_tab[1] = 16'd100; y_tab[2] = 16'd200; y_tab[3] = 16'hFFCE;
        run_sample("t1", 3'b111, 16'h1234, 0, lat, res);
        chk("t1_result", 32'(res), 32'd250);
        chk("t1_latency", 32'(lat), 32'd8);
        chk("t1_issues", 32'(issue_cnt), 32'd3);
        chk("t1_sel0", 32'(issue_sel[0]), 32'd1);
        chk("t1_sel1", 32'(issue_sel[1]), 32'd2);
        chk("t1_sel2", 32'(issue_sel[2]), 32'd3);
        chk("t1_x", 32'(issue_x[0]), 32'h1234);
        chk("t1_overrun", 32'(overrun), 32'd0);

        // 2: section 2 only, -300
        y_tab[2] = 16'hFED4;
        run_sample("t2", 3'b010, 16'h0042, 0, lat, res);
        chk("t2_result", 32'(res), 32'h0000FED4);
        chk("t2_latency", 32'(lat), 32'd4);
        chk("t2_issues", 32'(issue_cnt), 32'd1);
        chk("t2_sel0", 32'(issue_sel[0]), 32'd2);

        // 3: nothing enabled
        run_sample("t3", 3'b000, 16'h0007, 0, lat, res);
        chk("t3_result", 32'(res), 32'd0);
        chk("t3_latency", 32'(lat), 32'd2);
        chk("t3_issues", 32'(issue_cnt), 32'd0);

        // 4: 3 x 30000 overflows N bits
        y_tab[1] = 16'd30000; y_tab[2] = 16'd30000; y_tab[3] = 16'd30000;
        run_sample("t4", 3'b111, 16'h0001, 0, lat, res);
`ifdef SATURATION_EN
        chk("t4_result", 32'(res), 32'd32767);
`else
        chk("t4_result", 32'(res), 32'd24464);
`endif

        // 5: extra tick during WAIT is ignored and flagged
        y_tab[1] = 16'd1; y_tab[2] = 16'd2; y_tab[3] = 16'd3;
        run_sample("t5", 3'b111, 16'h0BEE, 2, lat, res);
        chk("t5_result", 32'(res), 32'd6);
        chk("t5_latency", 32'(lat), 32'd8);
        chk("t5_issues", 32'(issue_cnt), 32'd3);
        chk("t5_x_stable", 32'(issue_x[2]), 32'h0BEE);
        chk("t5_overrun", 32'(overrun), 32'd1);
        run_sample("t5b", 3'b001, 16'h0003, 0, lat, res);
        chk("t5b_result", 32'(res), 32'd1);
        chk("t5b_overrun_sticky", 32'(overrun), 32'd1);

        // 6: section 1 never answers -> timeout, sections 2 and 3 still run
        hang_en = 1; hang_sel = 2'd1;
        y_tab[2] = 16'd5; y_tab[3] = 16'd7;
        run_sample("t6", 3'b111, 16'h0055, 0, lat, res);
        chk("t6_result", 32'(res), 32'd12);
        chk("t6_latency", 32'(lat), 32'd262);
        chk("t6_issues", 32'(issue_cnt), 32'd3);
        chk("t6_sel2", 32'(issue_sel[2]), 32'd3);
        chk("t6_timeout", 32'(timeout_err), 32'd1);

        // 6b: reset mid-WAIT
        issue_cnt = 0;
        {sw3, sw2, sw1} = 3'b111;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("t6b_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6b_busy", 32'(busy), 32'd0);
        chk("t6b_result", 32'(result), 32'd0);
        chk("t6b_overrun", 32'(overrun), 32'd0);
        chk("t6b_timeout", 32'(timeout_err), 32'd0);
        chk("t6b_start", 32'(bus.sec_start), 32'd0);
        chk("t6b_sel", 32'(bus.sec_sel), 32'd0);
        reset = 1'b0;
        hang_en = 0;
        @(posedge clk);
        #1;
        run_sample("t6c", 3'b100, 16'h0009, 0, lat, res);
        chk("t6c_result", 32'(res), 32'd7);
        chk("t6c_latency", 32'(lat), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
